// File: rtl/retro_vending_multi.sv
// -----------------------------------------------------------------------------
// retro_vending_multi
//
// Multi-product vending controller. Accepts 5/10/25-cent coins into a bounded
// credit register, sells one of NUM_ITEMS products with individual prices and
// stock counters, and pays change back one coin per handshake.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   coin_5/10/25   one-cycle coin-accepted pulses from the coin mech
//   next_item      pulse, advance item selection (wraps)
//   select         pulse, attempt purchase of the selected item
//   cancel         pulse, refund the whole credit as change
//   restock        pulse, reload every stock counter to INIT_STOCK
//   change_ready   coin-return mechanism can take a coin
//   item_sel       currently selected item
//   credit         current credit in cents
//   dispense       one-cycle pulse, item dispensed
//   dispense_item  index of the dispensed item, valid with dispense
//   deny           one-cycle pulse, previous select refused
//   coin_reject    one-cycle pulse, coins of the previous cycle refused
//   sold_out       stock of item_sel is zero
//   change_valid   a change coin is offered
//   change_denom   0=5c, 1=10c, 2=25c, valid with change_valid
//   busy           controller is not idle
// -----------------------------------------------------------------------------
module retro_vending_multi #(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd65, 8'd50, 8'd35, 8'd25},
    parameter int                            MAX_CREDIT = 100,
    parameter int                            STOCK_W    = 4,
    parameter int                            INIT_STOCK = 5,
    localparam int                           IDX_W      = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                coin_25,
    input  logic                next_item,
    input  logic                select,
    input  logic                cancel,
    input  logic                restock,
    input  logic                change_ready,
    output logic [IDX_W-1:0]    item_sel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [IDX_W-1:0]    dispense_item,
    output logic                deny,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                change_valid,
    output logic [1:0]          change_denom,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    item_sel_q, item_sel_d;
    logic [IDX_W-1:0]    vend_item_q, vend_item_d;
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
    logic                dispense_q, dispense_d;
    logic                deny_q, deny_d;
    logic                coin_reject_q, coin_reject_d;

    // Coin arithmetic is one bit wider so credit+sum cannot wrap before the
    // ceiling compare.
    logic                coin_any;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   credit_plus;
    logic                coins_fit;
    logic [CREDIT_W-1:0] price_sel;
    logic [STOCK_W-1:0]  stock_sel;
    logic                can_buy;
    logic [CREDIT_W-1:0] denom_amt;
    logic [1:0]          denom_code;

    always_comb begin
        coin_any    = coin_5 | coin_10 | coin_25;
        coin_sum    = (coin_5  ? (CREDIT_W+1)'(5)  : '0)
                    + (coin_10 ? (CREDIT_W+1)'(10) : '0)
                    + (coin_25 ? (CREDIT_W+1)'(25) : '0);
        credit_plus = {1'b0, credit_q} + coin_sum;
        coins_fit   = credit_plus <= (CREDIT_W+1)'(MAX_CREDIT);
        price_sel   = PRICES[int'(item_sel_q)*CREDIT_W +: CREDIT_W];
        stock_sel   = stock_q[item_sel_q];
        can_buy     = (credit_q >= price_sel) && (stock_sel != '0);
    end

    // Greedy change: largest coin not exceeding the remaining credit. Credit is
    // always a multiple of 5, so the 5c fallback never overshoots a nonzero credit.
    always_comb begin
        if (credit_q >= CREDIT_W'(25)) begin
            denom_code = 2'd2;
            denom_amt  = CREDIT_W'(25);
        end else if (credit_q >= CREDIT_W'(10)) begin
            denom_code = 2'd1;
            denom_amt  = CREDIT_W'(10);
        end else begin
            denom_code = 2'd0;
            denom_amt  = CREDIT_W'(5);
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d       = state_q;
        credit_d      = credit_q;
        item_sel_d    = item_sel_q;
        vend_item_d   = vend_item_q;
        stock_d       = stock_q;
        dispense_d    = 1'b0;
        deny_d        = 1'b0;
        coin_reject_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cancel) begin
                    // Cancel swallows the cycle's coins whether or not there
                    // is credit to return.
                    if (credit_q != '0) state_d = S_CHANGE;
                    coin_reject_d = coin_any;
                end else if (select && can_buy) begin
                    state_d                = S_VEND;
                    vend_item_d            = item_sel_q;
                    credit_d               = credit_q - price_sel;
                    stock_d[item_sel_q]    = stock_sel - STOCK_W'(1);
                    dispense_d             = 1'b1;
                    coin_reject_d          = coin_any;
                end else begin
                    // A refused select still outranks next_item, but the
                    // coins of this cycle are counted.
                    if (select) begin
                        deny_d = 1'b1;
                    end else if (next_item) begin
                        item_sel_d = (item_sel_q == IDX_W'(NUM_ITEMS-1)) ? '0
                                   : item_sel_q + IDX_W'(1);
                    end
                    if (coin_any) begin
                        if (coins_fit) credit_d = credit_plus[CREDIT_W-1:0];
                        else           coin_reject_d = 1'b1;
                    end
                end
            end

            S_VEND: begin
                coin_reject_d = coin_any;
                state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                coin_reject_d = coin_any;
                if (change_ready && (credit_q >= denom_amt)) begin
                    credit_d = credit_q - denom_amt;
                    if (credit_q == denom_amt) state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Restock overrides any decrement made above in the same cycle.
        if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(INIT_STOCK);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            item_sel_q    <= '0;
            vend_item_q   <= '0;
            dispense_q    <= 1'b0;
            deny_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            // NOTE: the stock array is reset deliberately; it must hold
            // INIT_STOCK after reset, so it is flops, not a RAM.
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_sel_q    <= item_sel_d;
            vend_item_q   <= vend_item_d;
            dispense_q    <= dispense_d;
            deny_q        <= deny_d;
            coin_reject_q <= coin_reject_d;
            stock_q       <= stock_d;
        end
    end

    assign item_sel      = item_sel_q;
    assign credit        = credit_q;
    assign dispense      = dispense_q;
    assign dispense_item = vend_item_q;
    assign deny          = deny_q;
    assign coin_reject   = coin_reject_q;
    assign sold_out      = (stock_sel == '0);
    assign change_valid  = (state_q == S_CHANGE);
    assign change_denom  = denom_code;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_retro_vending_multi.sv
// -----------------------------------------------------------------------------
// Testbench for retro_vending_multi (default parameters: prices item0=25,
// item1=35, item2=50, item3=65; ceiling 100; stock 5).
// Directed stimulus pushes the expected output events (dispense, deny,
// coin_reject, change coin) into a queue; an independent monitor pops and
// compares each event the DUT presents. State values are checked inline.
// -----------------------------------------------------------------------------
module tb_retro_vending_multi;

    localparam int NUM_ITEMS = 4;
    localparam int CREDIT_W  = 8;
    localparam int IDX_W     = $clog2(NUM_ITEMS);

    typedef enum int { EV_DISP, EV_DENY, EV_REJ, EV_CHG } ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       val;
    } ev_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                coin_5, coin_10, coin_25;
    logic                next_item, select, cancel, restock, change_ready;
    logic [IDX_W-1:0]    item_sel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [IDX_W-1:0]    dispense_item;
    logic                deny, coin_reject, sold_out, change_valid, busy;
    logic [1:0]          change_denom;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    retro_vending_multi dut (
        .clk           (clk),
        .reset         (rst_n),
        .coin_5        (coin_5),
        .coin_10       (coin_10),
        .coin_25       (coin_25),
        .next_item     (next_item),
        .select        (select),
        .cancel        (cancel),
        .restock       (restock),
        .change_ready  (change_ready),
        .item_sel      (item_sel),
        .credit        (credit),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .deny          (deny),
        .coin_reject   (coin_reject),
        .sold_out      (sold_out),
        .change_valid  (change_valid),
        .change_denom  (change_denom),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %s val %0d expected none", kind.name(), val);
        end else begin
            e = exp_q.pop_front();
            check({"event_kind_", e.kind.name()}, int'(kind), int'(e.kind));
            check({"event_val_", e.kind.name()}, val, e.val);
        end
    endtask

    // Monitor: outputs and change_ready are stable at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dispense)                    observe(EV_DISP, int'(dispense_item));
                if (deny)                        observe(EV_DENY, 0);
                if (coin_reject)                 observe(EV_REJ, 0);
                if (change_valid && change_ready) observe(EV_CHG, int'(change_denom));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coins(input bit c5, input bit c10, input bit c25);
        coin_5 = c5; coin_10 = c10; coin_25 = c25;
        tick();
        coin_5 = 0; coin_10 = 0; coin_25 = 0;
    endtask

    task automatic do_select();
        select = 1; tick(); select = 0;
    endtask

    task automatic do_next();
        next_item = 1; tick(); next_item = 0;
    endtask

    task automatic do_cancel();
        cancel = 1; tick(); cancel = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 50 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        {coin_5, coin_10, coin_25, next_item, select, cancel, restock, change_ready} = '0;
        #23 rst_n = 1;
        tick();

        // Reset state
        check("rst_credit", credit, 0);
        check("rst_item_sel", item_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_change_valid", change_valid, 0);
        check("rst_sold_out", sold_out, 0);
        check("rst_dispense_item", dispense_item, 0);

        // Purchase with change: 25+25+10 = 60, item 1 costs 35 -> 25 back as one 25c
        coins(0, 0, 1);
        coins(0, 0, 1);
        coins(0, 1, 0);
        check("credit_60", credit, 60);
        do_next();
        check("item_sel_1", item_sel, 1);
        change_ready = 1;
        expect_ev(EV_DISP, 1);
        expect_ev(EV_CHG, 2);
        do_select();
        check("vend_credit_25", credit, 25);
        check("vend_busy", busy, 1);
        wait_idle("purchase");
        check("purchase_credit_0", credit, 0);

        // Ceiling: 75, then 10+5 same cycle -> 90, overflow reject, exact fill
        coins(0, 0, 1);
        coins(0, 0, 1);
        coins(0, 0, 1);
        coins(1, 1, 0);
        check("credit_90", credit, 90);
        expect_ev(EV_REJ, 0);
        coins(1, 1, 0);
        check("reject_credit_90", credit, 90);
        coins(0, 1, 0);
        check("credit_100", credit, 100);
        expect_ev(EV_REJ, 0);
        coins(1, 0, 0);
        check("full_credit_100", credit, 100);
        repeat (4) expect_ev(EV_CHG, 2);
        do_cancel();
        wait_idle("refund_100");
        check("refund_credit_0", credit, 0);

        // Deny on insufficient credit, then stalled change 10+10
        change_ready = 0;
        coins(0, 1, 0);
        coins(0, 1, 0);
        do_next();
        check("item_sel_2", item_sel, 2);
        expect_ev(EV_DENY, 0);
        do_select();
        check("deny_credit_20", credit, 20);
        check("deny_busy", busy, 0);
        do_cancel();
        repeat (5) tick();
        check("stall_change_valid", change_valid, 1);
        check("stall_credit_20", credit, 20);
        check("stall_denom", change_denom, 1);
        expect_ev(EV_CHG, 1);
        expect_ev(EV_CHG, 1);
        change_ready = 1;
        wait_idle("stalled_refund");
        check("stalled_credit_0", credit, 0);

        // Cancel with no credit does nothing
        do_cancel();
        check("cancel_empty_busy", busy, 0);

        // Selection wrap
        do_next();
        do_next();
        check("wrap_item_sel_0", item_sel, 0);
        for (int i = 0; i < NUM_ITEMS; i++) do_next();
        check("full_cycle_item_sel_0", item_sel, 0);

        // Sell out item 0 (price 25, exact credit each time)
        for (int i = 0; i < 5; i++) begin
            check("stock_left_sold_out", sold_out, 0);
            coins(0, 0, 1);
            expect_ev(EV_DISP, 0);
            do_select();
            wait_idle("sell");
            check("sell_credit_0", credit, 0);
        end
        check("sold_out_item0", sold_out, 1);
        coins(0, 0, 1);
        expect_ev(EV_DENY, 0);
        do_select();
        check("soldout_deny_credit", credit, 25);
        check("soldout_deny_busy", busy, 0);
        restock = 1; tick(); restock = 0;
        check("restock_sold_out", sold_out, 0);

        // Coin during CHANGE is rejected, credit untouched
        change_ready = 0;
        do_cancel();
        check("change_busy", busy, 1);
        expect_ev(EV_REJ, 0);
        coins(0, 1, 0);
        check("change_coin_credit_25", credit, 25);
        expect_ev(EV_CHG, 2);
        change_ready = 1;
        wait_idle("change_coin");
        check("change_coin_credit_0", credit, 0);

        // Asynchronous reset during CHANGE with credit 40
        change_ready = 0;
        coins(1, 1, 1);
        check("credit_40", credit, 40);
        do_cancel();
        check("pre_reset_valid", change_valid, 1);
        check("pre_reset_denom", change_denom, 2);
        #2 rst_n = 0;
        #1;
        check("async_credit_0", credit, 0);
        check("async_change_valid_0", change_valid, 0);
        check("async_busy_0", busy, 0);
        tick();
        #2 rst_n = 1;
        tick();
        check("post_reset_busy", busy, 0);
        check("post_reset_credit", credit, 0);
        check("post_reset_item_sel", item_sel, 0);

        repeat (3) tick();
        check("events_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
